// File: rtl/xbus_select_sequencer_pkg.sv
// Shared definitions for the decoder select sequencer: state encoding,
// decoder enable patterns and the phase-counter width rule.
package xbus_select_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } seq_state_t;

  // {g1, g2a_n, g2b_n}
  localparam logic [2:0] ENABLES_OFF = 3'b011;
  localparam logic [2:0] ENABLES_ON  = 3'b100;

  // The counter is loaded with (cycles - 1), so clog2 of the longest phase suffices.
  function automatic int cnt_width(input int len_w, input int setup_cyc, input int hold_cyc);
    int longest;
    int w;
    longest = (setup_cyc > hold_cyc) ? setup_cyc : hold_cyc;
    w = (longest > 1) ? $clog2(longest) : 1;
    return (len_w > w) ? len_w : w;
  endfunction

endpackage

// File: rtl/xbus_select_sequencer_sel_cycle_counter.sv
// Loadable down-counter shared by the setup, strobe and hold phases; it
// saturates at zero and flags it.
module sel_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // load has priority over decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/xbus_select_sequencer.sv
// Setup / strobe / hold sequencer driving a 3-to-8 select decoder; exactly one
// enable strobe per accepted request, address only changes while disabled.
module xbus_select_sequencer
  import xbus_select_sequencer_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int LEN_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_dev,
  input  logic [LEN_W-1:0] req_len,
  input  logic             dev_wait,
  output logic             sel_a,
  output logic             sel_b,
  output logic             sel_c,
  output logic             sel_g1,
  output logic             sel_g2a_n,
  output logic             sel_g2b_n,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(LEN_W, SETUP_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LOAD = (SETUP_CYC > 0) ? CW'(SETUP_CYC - 1) : '0;
  localparam logic [CW-1:0] HOLD_LOAD  = (HOLD_CYC > 0)  ? CW'(HOLD_CYC - 1)  : '0;

  seq_state_t       state;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] eff_len_m1;
  logic             accept;
  logic             strobe_end;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CW-1:0]    cnt_val;

  // A zero length is treated as a single strobe cycle
  assign eff_len_m1 = (req_len == '0) ? '0 : (req_len - LEN_W'(1));
  assign accept     = req_valid && req_ready;
  assign strobe_end = (state == ST_STROBE) && cnt_zero && !dev_wait;

  // Counter control: reload on entry to each phase, otherwise count down
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (SETUP_CYC > 0) begin
            cnt_val = SETUP_LOAD;
          end else begin
            cnt_val = CW'(eff_len_m1);
          end
        end else begin
          cnt_load = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CW'(len_m1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (strobe_end && (HOLD_CYC > 0)) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LOAD;
        end else begin
          cnt_dec = !cnt_zero;
        end
      end
      ST_HOLD: begin
        cnt_dec = !cnt_zero;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  sel_cycle_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sequencer FSM; outputs are set from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                            <= ST_IDLE;
      len_m1                           <= '0;
      {sel_c, sel_b, sel_a}            <= 3'b000;
      {sel_g1, sel_g2a_n, sel_g2b_n}   <= ENABLES_OFF;
      req_ready                        <= 1'b1;
      busy                             <= 1'b0;
      done                             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            len_m1                <= eff_len_m1;
            {sel_c, sel_b, sel_a} <= req_dev;
            busy                  <= 1'b1;
            req_ready             <= 1'b0;
            if (SETUP_CYC > 0) begin
              state                          <= ST_SETUP;
              {sel_g1, sel_g2a_n, sel_g2b_n} <= ENABLES_OFF;
            end else begin
              state                          <= ST_STROBE;
              {sel_g1, sel_g2a_n, sel_g2b_n} <= ENABLES_ON;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state                          <= ST_STROBE;
            {sel_g1, sel_g2a_n, sel_g2b_n} <= ENABLES_ON;
          end
        end
        ST_STROBE: begin
          if (strobe_end) begin
            {sel_g1, sel_g2a_n, sel_g2b_n} <= ENABLES_OFF;
            if (HOLD_CYC > 0) begin
              state <= ST_HOLD;
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
              done      <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: begin
          state                          <= ST_IDLE;
          {sel_g1, sel_g2a_n, sel_g2b_n} <= ENABLES_OFF;
          busy                           <= 1'b0;
          req_ready                      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_select_sequencer.sv
// Randomized bench for two sequencer configurations (default and zero setup/hold)
// checked every cycle against a phase/cycle-count model plus literal timelines.
module tb_xbus_select_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_dev = 3'd0;
  logic [3:0] req_len = 4'd0;
  logic       dev_wait = 1'b0;

  logic d0_ready, d0_a, d0_b, d0_c, d0_g1, d0_g2a, d0_g2b, d0_busy, d0_done;
  logic d1_ready, d1_a, d1_b, d1_c, d1_g1, d1_g2a, d1_g2b, d1_busy, d1_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xbus_select_sequencer #(.SETUP_CYC(1), .HOLD_CYC(1), .LEN_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d0_ready),
    .req_dev(req_dev), .req_len(req_len), .dev_wait(dev_wait),
    .sel_a(d0_a), .sel_b(d0_b), .sel_c(d0_c), .sel_g1(d0_g1),
    .sel_g2a_n(d0_g2a), .sel_g2b_n(d0_g2b), .busy(d0_busy), .done(d0_done)
  );

  xbus_select_sequencer #(.SETUP_CYC(0), .HOLD_CYC(0), .LEN_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d1_ready),
    .req_dev(req_dev), .req_len(req_len), .dev_wait(dev_wait),
    .sel_a(d1_a), .sel_b(d1_b), .sel_c(d1_c), .sel_g1(d1_g1),
    .sel_g2a_n(d1_g2a), .sel_g2b_n(d1_g2b), .busy(d1_busy), .done(d1_done)
  );

  // Model: phase 0 idle, 1 setup, 2 strobe, 3 hold; cnt = cycle number within phase
  int         m_phase [2];
  int         m_cnt   [2];
  int         m_len   [2];
  logic [2:0] m_dev   [2];
  logic       m_done  [2];

  function automatic int setup_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_phase[k] <= 0;
        m_cnt[k]   <= 0;
        m_len[k]   <= 1;
        m_dev[k]   <= 3'd0;
        m_done[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        case (m_phase[k])
          0: if (req_valid) begin
            m_dev[k]   <= req_dev;
            m_len[k]   <= (req_len == 4'd0) ? 1 : int'(req_len);
            m_phase[k] <= (setup_of(k) > 0) ? 1 : 2;
            m_cnt[k]   <= 1;
          end
          1: if (m_cnt[k] >= setup_of(k)) begin
            m_phase[k] <= 2;
            m_cnt[k]   <= 1;
          end else m_cnt[k] <= m_cnt[k] + 1;
          2: if (m_cnt[k] >= m_len[k] && !dev_wait) begin
            if (hold_of(k) > 0) begin
              m_phase[k] <= 3;
              m_cnt[k]   <= 1;
            end else begin
              m_phase[k] <= 0;
              m_done[k]  <= 1'b1;
            end
          end else m_cnt[k] <= m_cnt[k] + 1;
          3: if (m_cnt[k] >= hold_of(k)) begin
            m_phase[k] <= 0;
            m_done[k]  <= 1'b1;
          end else m_cnt[k] <= m_cnt[k] + 1;
          default: m_phase[k] <= 0;
        endcase
      end
    end
  end

  // Vector layout: {ready, busy, done, g1, g2a_n, g2b_n, c, b, a}
  function automatic logic [8:0] exp_vec(input int k);
    logic on;
    on = (m_phase[k] == 2);
    return {m_phase[k] == 0, m_phase[k] != 0, m_done[k], on, !on, !on, m_dev[k]};
  endfunction

  function automatic logic [8:0] obs_vec(input int k);
    if (k == 0)
      return {d0_ready, d0_busy, d0_done, d0_g1, d0_g2a, d0_g2b, d0_c, d0_b, d0_a};
    return {d1_ready, d1_busy, d1_done, d1_g1, d1_g2a, d1_g2b, d1_c, d1_b, d1_a};
  endfunction

  // 74S138 outputs Y7..Y0 seen by the decoder for a given output vector
  function automatic logic [7:0] decode(input logic [8:0] v);
    logic [7:0] one;
    one = 8'd1;
    if (v[5] && !v[4] && !v[3]) return ~(one << v[2:0]);
    return 8'hFF;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check((k == 0) ? "dut0_outputs" : "dut1_outputs", 16'(obs_vec(k)), 16'(exp_vec(k)));
      check((k == 0) ? "dut0_decoder" : "dut1_decoder", 16'(decode(obs_vec(k))), 16'(decode(exp_vec(k))));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  logic [12:0] busy0, g1_0, done0, busy1, done1;
  bit          found;
  int          r;

  initial begin
    busy0 = 13'b0111111011110;
    g1_0  = 13'b0011110001100;
    done0 = 13'b1000000100000;
    busy1 = 13'b0000001000110;
    done1 = 13'b0000010001000;

    #1 reset = 1'b1;
    #11 reset = 1'b0;

    // cycle 0: idle after reset
    step();
    check("rst_enables", 16'({d0_g1, d0_g2a, d0_g2b}), 16'(3'b011));
    check("rst_ready_busy_done", 16'({d0_ready, d0_busy, d0_done}), 16'(3'b100));
    check("rst_decoder", 16'(decode(obs_vec(0))), 16'(8'hFF));
    check("rst_sel", 16'({d0_c, d0_b, d0_a}), 16'(3'b000));
    req_valid = 1'b1; req_dev = 3'd5; req_len = 4'd2;

    for (int c = 1; c <= 12; c++) begin
      step();
      check("lit_busy0", 16'(d0_busy), 16'(busy0[c]));
      check("lit_g1_0", 16'(d0_g1), 16'(g1_0[c]));
      check("lit_done0", 16'(d0_done), 16'(done0[c]));
      check("lit_busy1", 16'(d1_busy), 16'(busy1[c]));
      check("lit_done1", 16'(d1_done), 16'(done1[c]));
      check("lit_model_busy0", 16'(m_phase[0] != 0), 16'(busy0[c]));
      check("lit_model_done1", 16'(m_done[1]), 16'(done1[c]));
      if (c == 2 || c == 3) check("lit_y5_low", 16'(decode(obs_vec(0))), 16'(8'hDF));
      if (c == 5) check("lit_addr_held", 16'({d0_c, d0_b, d0_a}), 16'(3'b101));
      if (c == 7) check("lit_y2_low", 16'(decode(obs_vec(0))), 16'(8'hFB));
      if (c == 1) req_valid = 1'b0;
      if (c == 5) begin req_valid = 1'b1; req_dev = 3'd2; req_len = 4'd0; end
      if (c == 6) req_valid = 1'b0;
      if (c >= 7 && c <= 9) dev_wait = 1'b1;
      if (c == 10) dev_wait = 1'b0;
    end

    // Reset in the middle of a strobe
    req_valid = 1'b1; req_dev = 3'd6; req_len = 4'd5;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      req_valid = 1'b0;
      if (m_phase[0] == 2) found = 1'b1;
    end
    check("strobe_reached", 16'(found), 16'(1'b1));
    #2 reset = 1'b1;
    #1;
    check("async_rst_enables", 16'({d0_g1, d0_g2a, d0_g2b}), 16'(3'b011));
    check("async_rst_status", 16'({d0_ready, d0_busy, d0_done, d0_c, d0_b, d0_a}), 16'(6'b100000));
    #1 reset = 1'b0;
    req_valid = 1'b1; req_dev = 3'd3; req_len = 4'd1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic, including maximum length and rare resets
    for (int i = 0; i < 4000; i++) begin
      step();
      reset     = ($urandom_range(0, 599) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_dev   = 3'($urandom_range(0, 7));
      r         = $urandom_range(0, 9);
      req_len   = (r == 0) ? 4'd15 : (r == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      dev_wait  = ($urandom_range(0, 2) == 0);
    end
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
